s832_flag_encoder: RTL and testbench
====================================

Name: s832_flag_encoder

Overview:
- Re-encodes the 19 one-hot-style decode flags from the s832 controller into a compact, run-length-compressed event stream.
- The controller expands its 5-bit state into flags; this block collapses the flags back into a 5-bit code, counts how many consecutive samples carry that code, and buffers the resulting records in a small FIFO.
- Sits between the controller outputs and the trace/readback logic, which drains the FIFO with a valid/ready handshake.

Parameters:
NFLAG, 19, number of flag inputs (code width is fixed at 5 bits, so NFLAG must be 31 or less)
DEPTH, 4, record FIFO depth (power of 2)
CNTW, 8, run counter width; saturates at 2^CNTW-1

Ports:
CK  input  1  clock; all state updates on the rising edge
RN  input  1  asynchronous active-low reset
EN  input  1  sample strobe; FLAGS are sampled only when EN=1
FLAGS  input  NFLAG  flag vector from the controller
FLUSH  input  1  close the open run and push it as a record
REC_VALID  output  1  FIFO head record is valid
REC_READY  input  1  consumer accepts the head record
REC_CODE  output  5  head record code
REC_MULTI  output  1  head record had more than one flag set
REC_RUN  output  CNTW  head record run length, 1..2^CNTW-1
LEVEL  output  clog2(DEPTH)+1  FIFO occupancy
OVF  output  1  sticky flag: a record was dropped
CLR_OVF  input  1  synchronous clear of OVF

Behaviour:
- Reset (RN=0, asynchronous):
  - FIFO empty, so REC_VALID=0 and LEVEL=0.
  - REC_CODE=0, REC_MULTI=0, REC_RUN=0, OVF=0.
  - FSM goes to IDLE and the accumulator is cleared.
  - A reset mid-run discards the open run and all buffered records.
- Encoding (combinational on FLAGS):
  - code = 1 + index of the lowest set bit; FLAGS=0 gives code 0.
  - multi = 1 when two or more bits are set.
- The accumulator holds {code, multi, run}. The FSM has two states:
  - IDLE, on EN=1: load {code, multi, run=1} and go to ACC.
  - ACC, on EN=1 with {code, multi} equal to the accumulator and run < max: run += 1.
  - ACC, on EN=1 with {code, multi} different: push the accumulator, load {code, multi, 1}, stay in ACC.
  - ACC, on EN=1 with equal key and run == max: push the accumulator with run=max, load {code, multi, 1}.
  - ACC, on FLUSH=1 with EN=0: push the accumulator and go to IDLE.
  - ACC, on FLUSH=1 with EN=1: push the accumulator, then load the new sample with run=1 and stay in ACC. The current sample is never merged into the flushed record.
  - IDLE, on FLUSH=1 with EN=0: no action.
- FIFO:
  - First-word-fall-through: a record pushed in cycle N has REC_VALID=1 in cycle N+1 if the FIFO was empty.
  - A pop happens when REC_VALID and REC_READY are both 1 at the clock edge.
  - REC_* outputs are stable while REC_VALID=1 and REC_READY=0.
  - Push and pop in the same cycle are both performed, even when the FIFO is full; LEVEL is unchanged.
  - Push while full with no pop: the record is dropped and OVF is set. The accumulator still advances as normal.
  - CLR_OVF clears OVF; if a drop occurs in the same cycle, the drop wins and OVF stays 1.
- LEVEL range: 0..DEPTH. REC_* outputs hold their last values when empty, qualified only by REC_VALID.
- Throughput: at most one push and one pop per cycle.

Test Plan:
- Reset, then EN=1 for 3 cycles with FLAGS=0x00004, then FLAGS=0x00010 for 1 cycle -> record {CODE=3, MULTI=0, RUN=3}, REC_VALID rises the cycle after FLAGS changes; FLUSH then pushes {CODE=5, RUN=1}.
- FLAGS=0x00006 for 2 cycles, then FLUSH with EN=0 -> record {CODE=2, MULTI=1, RUN=2}; FSM returns to IDLE; a second FLUSH yields no record.
- EN=1 with constant FLAGS=0x40000 for 300 cycles, then FLUSH, REC_READY=1 -> records {CODE=19, RUN=255} followed by {CODE=19, RUN=45}.
- REC_READY=0, alternate FLAGS 0x1/0x2 for 8 samples -> LEVEL saturates at 4 and OVF=1; records 1..4 read out in order with alternating codes 1,2,1,2; CLR_OVF clears OVF.
- FIFO full, REC_READY=1, new push in the same cycle -> no drop, OVF stays 0, LEVEL stays 4.
- RN pulsed low mid-run with LEVEL=2 -> REC_VALID=0 and LEVEL=0 immediately (asynchronously); the next sample starts at RUN=1.

Source files
------------

// File: rtl/s832_flag_encoder.sv
`default_nettype none
// ============================================================================
// Module      : s832_flag_encoder
// Description : Collapses the s832 controller's decode flags back into a
//               5-bit code and run-length compresses consecutive identical
//               samples. Completed runs are queued as records in a small
//               first-word-fall-through FIFO that is drained with a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CK        in   1           clock, rising edge
//   RN        in   1           asynchronous active-low reset
//   EN        in   1           sample strobe for FLAGS
//   FLAGS     in   NFLAG       flag vector from the controller
//   FLUSH     in   1           close the open run and push it as a record
//   REC_VALID out  1           FIFO head record is valid
//   REC_READY in   1           consumer accepts the head record
//   REC_CODE  out  5           head record code (1 + lowest set flag index)
//   REC_MULTI out  1           head record had more than one flag set
//   REC_RUN   out  CNTW        head record run length
//   LEVEL     out  log2(D)+1   FIFO occupancy
//   OVF       out  1           sticky: a record was dropped on a full FIFO
//   CLR_OVF   in   1           synchronous clear of OVF
// ============================================================================
module s832_flag_encoder #(
  parameter int NFLAG = 19,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       CK,
  input  logic                       RN,
  input  logic                       EN,
  input  logic [NFLAG-1:0]           FLAGS,
  input  logic                       FLUSH,
  output logic                       REC_VALID,
  input  logic                       REC_READY,
  output logic [4:0]                 REC_CODE,
  output logic                       REC_MULTI,
  output logic [CNTW-1:0]            REC_RUN,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       OVF,
  input  logic                       CLR_OVF
);

  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int REC_W = 5 + 1 + CNTW;
  localparam logic [CNTW-1:0] RUN_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] RUN_ONE = CNTW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Flag encoder
  // --------------------------------------------------------------------------
  logic [4:0] w_code;
  logic       w_multi;

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    w_code = 5'd0;
    for (int i = NFLAG - 1; i >= 0; i--) begin
      if (FLAGS[i]) begin
        w_code = 5'(i + 1);
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only if 2+ bits set.
  assign w_multi = |(FLAGS & (FLAGS - NFLAG'(1)));

  // --------------------------------------------------------------------------
  // Run accumulator / FSM
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [4:0]      acc_code_q, acc_code_d;
  logic            acc_multi_q, acc_multi_d;
  logic [CNTW-1:0] acc_run_q, acc_run_d;

  logic             w_key_match;
  logic             w_run_full;
  logic             w_push;
  logic [REC_W-1:0] w_push_rec;

  assign w_key_match = (w_code == acc_code_q) && (w_multi == acc_multi_q);
  assign w_run_full  = (acc_run_q == RUN_MAX);

  // The open run is closed by a flush, a key change, or counter saturation.
  // A flush takes priority even when the sample would otherwise merge.
  assign w_push     = (state_q == ST_ACC) &&
                      (FLUSH || (EN && (!w_key_match || w_run_full)));
  assign w_push_rec = {acc_code_q, acc_multi_q, acc_run_q};

  always_comb begin
    state_d     = state_q;
    acc_code_d  = acc_code_q;
    acc_multi_d = acc_multi_q;
    acc_run_d   = acc_run_q;
    if (EN) begin
      if ((state_q == ST_ACC) && !w_push) begin
        acc_run_d = acc_run_q + RUN_ONE;
      end else begin
        // Fresh run: either nothing was open or the open run was just pushed.
        acc_code_d  = w_code;
        acc_multi_d = w_multi;
        acc_run_d   = RUN_ONE;
        state_d     = ST_ACC;
      end
    end else if (FLUSH) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      acc_code_q  <= 5'd0;
      acc_multi_q <= 1'b0;
      acc_run_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_code_q  <= acc_code_d;
      acc_multi_q <= acc_multi_d;
      acc_run_q   <= acc_run_d;
    end
  end

  // --------------------------------------------------------------------------
  // Record FIFO
  // --------------------------------------------------------------------------
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    w_remaining;
  logic [REC_W-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;

  logic w_full;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full  = (level_q == LW'(DEPTH));
  assign w_pop   = REC_VALID && REC_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_comb begin
    wr_ptr_d    = w_wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = w_pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d     = level_q + LW'(w_wr_en) - LW'(w_pop);
    w_remaining = level_q - LW'(w_pop);

    // The head register presents the next record one cycle after it lands.
    // If entries remain after the pop, the new head is already in memory
    // (the slot being written can never be that entry). If the FIFO drains
    // to empty while a record arrives, it falls straight through. Otherwise
    // the last head is held.
    head_d = head_q;
    if (w_remaining != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (w_wr_en) begin
      head_d = w_push_rec;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_q;
    if (w_drop) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // Storage array is data only; validity is tracked by the pointers/level.
  always_ff @(posedge CK) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_push_rec;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign REC_VALID = (level_q != '0);
  assign REC_CODE  = head_q[REC_W-1 -: 5];
  assign REC_MULTI = head_q[CNTW];
  assign REC_RUN   = head_q[CNTW-1:0];
  assign LEVEL     = level_q;
  assign OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_s832_flag_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_s832_flag_encoder
// Description : Self-checking bench for s832_flag_encoder. Directed scenarios
//               followed by randomized traffic, all compared against a
//               record-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s832_flag_encoder;

  localparam int NFLAG = 19;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int RMAX  = (1 << CNTW) - 1;

  logic             CK = 1'b0;
  logic             RN;
  logic             EN;
  logic [NFLAG-1:0] FLAGS;
  logic             FLUSH;
  logic             REC_VALID;
  logic             REC_READY;
  logic [4:0]       REC_CODE;
  logic             REC_MULTI;
  logic [CNTW-1:0]  REC_RUN;
  logic [LW-1:0]    LEVEL;
  logic             OVF;
  logic             CLR_OVF;

  s832_flag_encoder #(.NFLAG(NFLAG), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CK(CK), .RN(RN), .EN(EN), .FLAGS(FLAGS), .FLUSH(FLUSH),
    .REC_VALID(REC_VALID), .REC_READY(REC_READY), .REC_CODE(REC_CODE),
    .REC_MULTI(REC_MULTI), .REC_RUN(REC_RUN), .LEVEL(LEVEL), .OVF(OVF),
    .CLR_OVF(CLR_OVF)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int code;
    int multi;
    int run;
  } rec_t;

  rec_t q[$];
  bit   m_open;
  rec_t m_acc;
  bit   m_ovf;
  rec_t m_last;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int enc_code(input logic [NFLAG-1:0] f);
    for (int i = 0; i < NFLAG; i++) if (f[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_open = 0;
    m_ovf  = 0;
    m_acc  = '{0, 0, 0};
    m_last = '{0, 0, 0};
  endtask

  task automatic model_step(input bit en, input logic [NFLAG-1:0] f,
                            input bit fl, input bit rdy, input bit clr);
    int   c;
    int   m;
    bit   pop;
    bit   push;
    bit   drop;
    rec_t pr;
    c    = enc_code(f);
    m    = ($countones(f) >= 2) ? 1 : 0;
    pop  = (q.size() > 0) && rdy;
    push = 0;
    drop = 0;
    if (m_open && (fl || (en && (c != m_acc.code || m != m_acc.multi ||
                                 m_acc.run == RMAX)))) begin
      push = 1;
      pr   = m_acc;
    end
    if (en) begin
      if (m_open && !push) m_acc.run++;
      else begin
        m_acc  = '{c, m, 1};
        m_open = 1;
      end
    end else if (fl) begin
      m_open = 0;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(pr);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_outputs();
    rec_t e;
    check_value("valid", REC_VALID, (q.size() > 0) ? 1 : 0);
    check_value("level", LEVEL, q.size());
    check_value("ovf", OVF, m_ovf);
    if (q.size() > 0) begin
      e      = q[0];
      m_last = q[0];
    end else begin
      e = m_last;
    end
    check_value("code", REC_CODE, e.code);
    check_value("multi", REC_MULTI, e.multi);
    check_value("run", REC_RUN, e.run);
  endtask

  // Called at a falling edge: drive, advance model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input bit en, input logic [NFLAG-1:0] f,
                       input bit fl, input bit rdy, input bit clr);
    EN = en; FLAGS = f; FLUSH = fl; REC_READY = rdy; CLR_OVF = clr;
    @(posedge CK);
    model_step(en, f, fl, rdy, clr);
    @(negedge CK);
    check_outputs();
  endtask

  initial begin
    logic [NFLAG-1:0] rf;
    RN = 1'b0; EN = 0; FLAGS = '0; FLUSH = 0; REC_READY = 0; CLR_OVF = 0;
    model_reset();
    repeat (2) @(negedge CK);
    check_outputs();
    RN = 1'b1;

    // T1: run of code 3 closed by a code change, then flushed code 5
    repeat (3) cycle(1, 19'h00004, 0, 0, 0);
    check_value("t1_pre_valid", REC_VALID, 0);
    cycle(1, 19'h00010, 0, 0, 0);
    check_value("t1_code", REC_CODE, 3);
    check_value("t1_run", REC_RUN, 3);
    cycle(0, '0, 1, 0, 0);
    check_value("t1_level", LEVEL, 2);
    repeat (2) cycle(0, '0, 0, 1, 0);

    // T2: multi-flag run, flush to IDLE, second flush does nothing
    repeat (2) cycle(1, 19'h00006, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    check_value("t2_code", REC_CODE, 2);
    check_value("t2_multi", REC_MULTI, 1);
    check_value("t2_run", REC_RUN, 2);
    cycle(0, '0, 1, 0, 0);
    check_value("t2_level", LEVEL, 1);
    cycle(0, '0, 0, 1, 0);

    // T3: counter saturation splits a 300-sample run into 255 + 45
    repeat (256) cycle(1, 19'h40000, 0, 1, 0);
    check_value("t3_code", REC_CODE, 19);
    check_value("t3_sat", REC_RUN, 255);
    repeat (44) cycle(1, 19'h40000, 0, 1, 0);
    cycle(0, '0, 1, 1, 0);
    check_value("t3_tail", REC_RUN, 45);
    cycle(0, '0, 0, 1, 0);

    // T4: overflow with a stalled consumer, ordered readout, clear
    for (int k = 0; k < 8; k++) cycle(1, (k % 2) ? 19'h2 : 19'h1, 0, 0, 0);
    check_value("t4_level", LEVEL, 4);
    check_value("t4_ovf", OVF, 1);
    for (int k = 0; k < 4; k++) begin
      check_value("t4_order", REC_CODE, (k % 2) ? 2 : 1);
      cycle(0, '0, 0, 1, 0);
    end
    cycle(0, '0, 0, 0, 1);
    check_value("t4_clr", OVF, 0);

    // T5: push into a full FIFO while the head is popped
    for (int k = 0; k < 4; k++) cycle(1, (k % 2) ? 19'h2 : 19'h1, 0, 0, 0);
    check_value("t5_full", LEVEL, 4);
    cycle(1, 19'h1, 0, 1, 0);
    check_value("t5_level", LEVEL, 4);
    check_value("t5_ovf", OVF, 0);

    // T6: asynchronous reset in the middle of a run
    repeat (2) cycle(0, '0, 0, 1, 0);
    cycle(1, 19'h1, 0, 0, 0);
    check_value("t6_level", LEVEL, 2);
    #2 RN = 1'b0;
    #1;
    check_value("t6_rst_valid", REC_VALID, 0);
    check_value("t6_rst_level", LEVEL, 0);
    model_reset();
    @(negedge CK);
    RN = 1'b1;
    check_outputs();
    cycle(1, 19'h00008, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    check_value("t6_code", REC_CODE, 4);
    check_value("t6_run", REC_RUN, 1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 5))
        0: rf = '0;
        1: rf = 19'h1;
        2: rf = 19'h2;
        3: rf = 19'h6;
        4: rf = 19'h40000;
        default: rf = NFLAG'($urandom);
      endcase
      cycle(($urandom_range(0, 9) < 7), rf, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
